enemy_ai_fsm: RTL and testbench
===============================

Name: enemy_ai_fsm

Overview:
- Parametrised next-generation opponent controller for the boxing game.
- Merges the enemy position FSM, tick divider and attack scheduler into one block.
- Adds N-lane movement, health tracking from hit pulses, an attack wind-up with stagger cancel, and a valid/ack attack handshake to the player-damage logic.
- Consumes random bits from the LFSR. Drives lane/pixel position and a redraw pulse to the VGA draw FSM.

Parameters:
- NUM_POS, 3, number of horizontal lanes (2..8).
- LANE_W, 2, lane index width; must satisfy 2^LANE_W >= NUM_POS.
- HEALTH_W, 4, health counter width.
- MAX_HEALTH, 10, health loaded at reset and on start.
- AGGR_THRESH, 6, aggressive mode when health < AGGR_THRESH.
- CALM_DIV, 100000000, clocks per tick in calm mode.
- AGGR_DIV, 50000000, clocks per tick in aggressive mode.
- MOVES_CALM, 4, moves between attacks (calm).
- MOVES_AGGR, 2, moves between attacks (aggressive).
- WIND_TICKS, 2, telegraph duration in ticks.
- ATK_TICKS, 1, attack_valid timeout in ticks.
- X_BASE, 20, pixel x of lane 0.
- X_STEP, 40, pixel spacing between lanes.
- Y_POS, 8, constant pixel y.
- START_POS, 1, lane loaded at reset and on start.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins or restarts a round.
- rnd  in  2  LFSR bits; sampled only on a move tick.
- hit  in  1  one-cycle pulse; player landed a punch.
- attack_ack  in  1  player logic accepts the attack.
- lane  out  LANE_W  current lane index.
- x_out  out  8  pixel x = X_BASE + lane*X_STEP.
- y_out  out  7  constant Y_POS.
- health  out  HEALTH_W  remaining health.
- aggressive  out  1  high while health < AGGR_THRESH and state is not DEAD.
- telegraph  out  1  high in WIND state (wind-up sprite).
- attack_valid  out  1  high in ATTACK state.
- attack_missed  out  1  one-cycle pulse on attack timeout.
- dead  out  1  high in DEAD state.
- draw_req  out  1  one-cycle pulse whenever lane or state changes.

Behaviour:
- Reset: state=IDLE; lane=START_POS; health=MAX_HEALTH; move_cnt=0; divider=0. All 1-bit outputs 0, except aggressive per its formula (0 when MAX_HEALTH >= AGGR_THRESH).
- States: IDLE, MOVE, WIND, ATTACK, RECOVER, DEAD.
- Divider: runs only in MOVE, WIND, ATTACK and RECOVER. Reloads (aggressive ? AGGR_DIV : CALM_DIV)-1 on state entry and on every tick. tick = divider==0. A mode change takes effect at the next reload only.
- IDLE: start -> MOVE; reload health, lane and move_cnt; assert draw_req.
- MOVE, on tick: rnd 00 = stay; 01 = lane-1, clamped at 0; 10 or 11 = lane+1, clamped at NUM_POS-1. Then move_cnt+1.
- MOVE: when the incremented move_cnt reaches (aggressive ? MOVES_AGGR : MOVES_CALM), go to WIND and clear move_cnt.
- WIND: after WIND_TICKS ticks -> ATTACK.
- ATTACK: attack_valid high.
  - attack_ack high in any cycle -> RECOVER next cycle.
  - Otherwise, after ATK_TICKS ticks: pulse attack_missed -> RECOVER.
- RECOVER: one tick -> MOVE.
- hit (all states except IDLE and DEAD): health-1, saturating at 0.
  - If the new health is 0 -> DEAD next cycle; this overrides every other transition.
  - Otherwise, a hit in WIND cancels the wind-up (stagger) -> RECOVER.
  - Hits in MOVE, ATTACK and RECOVER do not change state.
- Same cycle in ATTACK, hit and attack_ack: ack wins -> RECOVER, and health still decrements. If health reaches 0, DEAD wins.
- DEAD: dead=1 and aggressive=0; hit is ignored; start -> MOVE with a full reload.
- start outside IDLE and DEAD is ignored.
- reset in any state returns to the reset values on the next edge.
- draw_req: registered pulse the cycle after lane or state changes. No pulse on a stay move.
- x_out arithmetic is done at 8 bits. The parameter set must satisfy X_BASE + (NUM_POS-1)*X_STEP <= 255; this is not checked in hardware.

Test Plan:
Bench overrides CALM_DIV=4, AGGR_DIV=2 and keeps the other defaults.
1. Reset, then start; rnd=10 on every tick -> lane goes 1, then 2, then 2 (clamped); x_out goes 60, then 100; a draw_req pulse accompanies each change.
2. Hold rnd=00 -> WIND is entered exactly 16 clocks after start (4 moves x 4 clocks); telegraph is high for 8 clocks, then attack_valid rises. With ack held at 0, attack_missed pulses 4 clocks later.
3. In ATTACK, assert attack_ack in the first cycle -> attack_valid falls the next cycle; RECOVER lasts 4 clocks, then MOVE.
4. Send 5 hit pulses (health 10 -> 5) -> aggressive=1; after the next tick the divider period is 2 clocks; WIND follows after 2 moves.
5. Pulse hit during WIND -> RECOVER the next cycle; attack_valid never asserts; health decremented by 1.
6. Drive health to 1, then assert hit and attack_ack together in ATTACK -> DEAD, dead=1, health=0. A further hit has no effect; start -> MOVE with health=10 and lane=1.

Source files
------------

// File: rtl/enemy_ai_fsm.sv
// Opponent controller: lane movement, health from hit pulses, telegraphed attack with
// a valid/ack handshake, all paced by a tick divider whose period depends on the mode.
module enemy_ai_fsm #(
  parameter int NUM_POS     = 3,
  parameter int LANE_W      = 2,
  parameter int HEALTH_W    = 4,
  parameter int MAX_HEALTH  = 10,
  parameter int AGGR_THRESH = 6,
  parameter int CALM_DIV    = 100000000,
  parameter int AGGR_DIV    = 50000000,
  parameter int MOVES_CALM  = 4,
  parameter int MOVES_AGGR  = 2,
  parameter int WIND_TICKS  = 2,
  parameter int ATK_TICKS   = 1,
  parameter int X_BASE      = 20,
  parameter int X_STEP      = 40,
  parameter int Y_POS       = 8,
  parameter int START_POS   = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          rnd,
  input  logic                hit,
  input  logic                attack_ack,
  output logic [LANE_W-1:0]   lane,
  output logic [7:0]          x_out,
  output logic [6:0]          y_out,
  output logic [HEALTH_W-1:0] health,
  output logic                aggressive,
  output logic                telegraph,
  output logic                attack_valid,
  output logic                attack_missed,
  output logic                dead,
  output logic                draw_req
);

  localparam int DIV_MAX = (CALM_DIV > AGGR_DIV) ? CALM_DIV : AGGR_DIV;
  localparam int DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int CNT_W   = 8;
  localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(NUM_POS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MOVE, S_WIND, S_ATTACK, S_RECOVER, S_DEAD
  } state_t;

  state_t              state_q, state_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [HEALTH_W-1:0] health_q, health_d, health_dec;
  logic [DIV_W-1:0]    div_q, div_d, div_reload;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic                missed_q, missed_d;
  logic                draw_q, draw_d;
  logic                running_q, running_d;
  logic                tick, aggr;
  int                  move_lim;

  // Only the four in-round states count time and take hits.
  assign running_q  = (state_q == S_MOVE) || (state_q == S_WIND) ||
                      (state_q == S_ATTACK) || (state_q == S_RECOVER);
  assign tick       = running_q && (div_q == '0);
  assign aggr       = (int'(health_q) < AGGR_THRESH) && (state_q != S_DEAD);
  assign div_reload = aggr ? DIV_W'(AGGR_DIV - 1) : DIV_W'(CALM_DIV - 1);
  assign move_lim   = aggr ? MOVES_AGGR : MOVES_CALM;
  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign health_dec = (health_q == '0) ? '0 : health_q - HEALTH_W'(1);

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    health_d  = health_q;
    cnt_d     = cnt_q;
    missed_d  = 1'b0;
    running_d = 1'b0;
    div_d     = '0;
    draw_d    = 1'b0;

    case (state_q)
      S_IDLE, S_DEAD: begin
        if (start) begin
          state_d  = S_MOVE;
          lane_d   = LANE_W'(START_POS);
          health_d = HEALTH_W'(MAX_HEALTH);
        end
      end
      S_MOVE: begin
        if (tick) begin
          if (rnd == 2'b01) begin
            if (lane_q != '0) lane_d = lane_q - LANE_W'(1);
          end else if (rnd != 2'b00) begin
            if (lane_q != LANE_MAX) lane_d = lane_q + LANE_W'(1);
          end
          cnt_d = cnt_inc;
          if (int'(cnt_inc) >= move_lim) state_d = S_WIND;
        end
      end
      S_WIND: begin
        if (tick) begin
          cnt_d = cnt_inc;
          if (int'(cnt_inc) >= WIND_TICKS) state_d = S_ATTACK;
        end
      end
      S_ATTACK: begin
        if (attack_ack) begin
          state_d = S_RECOVER;
        end else if (tick) begin
          cnt_d = cnt_inc;
          if (int'(cnt_inc) >= ATK_TICKS) begin
            state_d  = S_RECOVER;
            missed_d = 1'b1;
          end
        end
      end
      S_RECOVER: begin
        if (tick) state_d = S_MOVE;
      end
      default: ;
    endcase

    // A lethal hit overrides everything; a survivable one only staggers the wind-up.
    if (running_q && hit) begin
      health_d = health_dec;
      if (health_dec == '0) begin
        state_d  = S_DEAD;
        missed_d = 1'b0;
      end else if (state_q == S_WIND) begin
        state_d = S_RECOVER;
      end
    end

    // One counter serves moves and ticks-in-state; it restarts on every state change.
    if (state_d != state_q) cnt_d = '0;

    running_d = (state_d == S_MOVE) || (state_d == S_WIND) ||
                (state_d == S_ATTACK) || (state_d == S_RECOVER);
    if (!running_d)                        div_d = '0;
    else if ((state_d != state_q) || tick) div_d = div_reload;
    else                                   div_d = div_q - DIV_W'(1);

    draw_d = (state_d != state_q) || (lane_d != lane_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      lane_q   <= LANE_W'(START_POS);
      health_q <= HEALTH_W'(MAX_HEALTH);
      div_q    <= '0;
      cnt_q    <= '0;
      missed_q <= 1'b0;
      draw_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      health_q <= health_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      missed_q <= missed_d;
      draw_q   <= draw_d;
    end
  end

  assign lane          = lane_q;
  assign x_out         = 8'(X_BASE) + 8'(lane_q) * 8'(X_STEP);
  assign y_out         = 7'(Y_POS);
  assign health        = health_q;
  assign aggressive    = aggr;
  assign telegraph     = (state_q == S_WIND);
  assign attack_valid  = (state_q == S_ATTACK);
  assign attack_missed = missed_q;
  assign dead          = (state_q == S_DEAD);
  assign draw_req      = draw_q;

endmodule

// File: tb/tb_enemy_ai_fsm.sv
// Randomised and scenario bench for enemy_ai_fsm, checked against a phase/time-left
// model of the opponent's behaviour.
module tb_enemy_ai_fsm;

  localparam int NUM_POS = 3, MAX_HEALTH = 10, AGGR_THRESH = 6;
  localparam int CALM_DIV = 4, AGGR_DIV = 2, MOVES_CALM = 4, MOVES_AGGR = 2;
  localparam int WIND_TICKS = 2, ATK_TICKS = 1;
  localparam int X_BASE = 20, X_STEP = 40, Y_POS = 8, START_POS = 1;

  localparam int M_IDLE = 0, M_MOVE = 1, M_WIND = 2, M_ATK = 3, M_REC = 4, M_DEAD = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b1, start = 1'b0, hit = 1'b0, attack_ack = 1'b0;
  logic [1:0] rnd = 2'b00;
  logic [1:0] lane;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [3:0] health;
  logic       aggressive, telegraph, attack_valid, attack_missed, dead, draw_req;
  logic [26:0] dut_out;

  int n_checks = 0, n_pass = 0;

  // Model: phase, lane, health, clocks left in the current tick period, count in phase.
  int m_state, m_lane, m_health, m_left, m_count;
  bit m_draw, m_missed;

  enemy_ai_fsm #(.CALM_DIV(CALM_DIV), .AGGR_DIV(AGGR_DIV)) dut (
    .clock(clock), .reset(reset), .start(start), .rnd(rnd), .hit(hit),
    .attack_ack(attack_ack), .lane(lane), .x_out(x_out), .y_out(y_out),
    .health(health), .aggressive(aggressive), .telegraph(telegraph),
    .attack_valid(attack_valid), .attack_missed(attack_missed), .dead(dead),
    .draw_req(draw_req)
  );

  always #5 clock = ~clock;

  assign dut_out = {lane, x_out, y_out, health, aggressive, telegraph,
                    attack_valid, attack_missed, dead, draw_req};

  function automatic logic [26:0] model_out();
    logic aggr;
    aggr = (m_health < AGGR_THRESH) && (m_state != M_DEAD);
    return {2'(m_lane), 8'(X_BASE + m_lane * X_STEP), 7'(Y_POS), 4'(m_health), aggr,
            m_state == M_WIND, m_state == M_ATK, m_missed, m_state == M_DEAD, m_draw};
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_lane = START_POS; m_health = MAX_HEALTH;
    m_left = 0; m_count = 0; m_draw = 0; m_missed = 0;
  endtask

  task automatic model_step(input bit st, input logic [1:0] r, input bit h, input bit a);
    int prev_state, prev_lane, nxt;
    bit active, tick, aggr;
    prev_state = m_state;
    prev_lane  = m_lane;
    active = (m_state >= M_MOVE) && (m_state <= M_REC);
    tick   = active && (m_left == 1);
    aggr   = (m_health < AGGR_THRESH) && (m_state != M_DEAD);
    nxt = m_state;
    m_missed = 0;
    case (m_state)
      M_IDLE, M_DEAD:
        if (st) begin nxt = M_MOVE; m_health = MAX_HEALTH; m_lane = START_POS; end
      M_MOVE:
        if (tick) begin
          if (r == 2'b01) m_lane = (m_lane > 0) ? m_lane - 1 : 0;
          else if (r != 2'b00) m_lane = (m_lane < NUM_POS - 1) ? m_lane + 1 : NUM_POS - 1;
          m_count++;
          if (m_count >= (aggr ? MOVES_AGGR : MOVES_CALM)) nxt = M_WIND;
        end
      M_WIND:
        if (tick) begin m_count++; if (m_count >= WIND_TICKS) nxt = M_ATK; end
      M_ATK:
        if (a) nxt = M_REC;
        else if (tick) begin
          m_count++;
          if (m_count >= ATK_TICKS) begin nxt = M_REC; m_missed = 1; end
        end
      M_REC:
        if (tick) nxt = M_MOVE;
      default: ;
    endcase
    if (active && h) begin
      if (m_health > 0) m_health--;
      if (m_health == 0) begin nxt = M_DEAD; m_missed = 0; end
      else if (m_state == M_WIND) nxt = M_REC;
    end
    if (nxt != m_state) m_count = 0;
    if (nxt >= M_MOVE && nxt <= M_REC) begin
      if (nxt != m_state || tick) m_left = aggr ? AGGR_DIV : CALM_DIV;
      else m_left--;
    end else begin
      m_left = 0;
    end
    m_draw  = (nxt != prev_state) || (m_lane != prev_lane);
    m_state = nxt;
  endtask

  task automatic step(input bit rs, input bit st, input logic [1:0] r, input bit h, input bit a);
    reset = rs; start = st; rnd = r; hit = h; attack_ack = a;
    @(posedge clock);
    #1;
    if (rs) model_reset();
    else model_step(st, r, h, a);
  endtask

  task automatic test_reset();
    step(1, 0, 2'b00, 0, 0);
    step(1, 1, 2'b11, 1, 1);
    n_checks++; if (lane !== 2'd1) $display("FAIL reset_lane: got %0d want 1", lane); else n_pass++;
    n_checks++; if (x_out !== 8'd60) $display("FAIL reset_x: got %0d want 60", x_out); else n_pass++;
    n_checks++; if (y_out !== 7'd8) $display("FAIL reset_y: got %0d want 8", y_out); else n_pass++;
    n_checks++; if (health !== 4'd10) $display("FAIL reset_health: got %0d want 10", health); else n_pass++;
    n_checks++;
    if ({aggressive, telegraph, attack_valid, attack_missed, dead, draw_req} !== 6'b0)
      $display("FAIL reset_flags: got %b want 000000",
               {aggressive, telegraph, attack_valid, attack_missed, dead, draw_req});
    else n_pass++;
  endtask

  task automatic test_move_clamp();
    step(1, 0, 2'b10, 0, 0);
    step(0, 1, 2'b10, 0, 0);
    n_checks++; if (draw_req !== 1'b1) $display("FAIL start_draw: got %b want 1", draw_req); else n_pass++;
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 2'b10, 0, 0);
      n_checks++;
      if (dut_out !== model_out()) $display("FAIL move_model: cyc %0d got %h want %h", i, dut_out, model_out());
      else n_pass++;
      if (i == 4) begin
        n_checks++;
        if ({lane, x_out, draw_req} !== {2'd2, 8'd100, 1'b1})
          $display("FAIL move_up: got lane %0d x %0d draw %b want 2 100 1", lane, x_out, draw_req);
        else n_pass++;
      end
      if (i == 8) begin
        n_checks++;
        if ({lane, x_out, draw_req} !== {2'd2, 8'd100, 1'b0})
          $display("FAIL move_clamp: got lane %0d x %0d draw %b want 2 100 0", lane, x_out, draw_req);
        else n_pass++;
      end
    end
  endtask

  task automatic test_wind_timing();
    int n;
    step(1, 0, 2'b00, 0, 0);
    step(0, 1, 2'b00, 0, 0);
    n = 0;
    while (!telegraph && n < 40) begin step(0, 0, 2'b00, 0, 0); n++; end
    n_checks++; if (n != 16) $display("FAIL wind_entry: got %0d clocks want 16", n); else n_pass++;
    n = 0;
    while (telegraph && n < 40) begin step(0, 0, 2'b00, 0, 0); n++; end
    n_checks++; if (n != 8) $display("FAIL wind_len: got %0d clocks want 8", n); else n_pass++;
    n_checks++; if (attack_valid !== 1'b1) $display("FAIL attack_rise: got %b want 1", attack_valid); else n_pass++;
    n = 0;
    while (!attack_missed && n < 40) begin step(0, 0, 2'b00, 0, 0); n++; end
    n_checks++; if (n != 4) $display("FAIL missed_time: got %0d clocks want 4", n); else n_pass++;
    n_checks++;
    if (dut_out !== model_out()) $display("FAIL wind_model: got %h want %h", dut_out, model_out());
    else n_pass++;
  endtask

  task automatic test_ack();
    int n;
    step(1, 0, 2'b00, 0, 0);
    step(0, 1, 2'b00, 0, 0);
    n = 0;
    while (!attack_valid && n < 60) begin step(0, 0, 2'b00, 0, 0); n++; end
    n_checks++; if (n != 24) $display("FAIL ack_reach: got %0d clocks want 24", n); else n_pass++;
    step(0, 0, 2'b00, 0, 1);
    n_checks++;
    if ({attack_valid, attack_missed, draw_req} !== 3'b001)
      $display("FAIL ack_fall: got av/miss/draw %b want 001", {attack_valid, attack_missed, draw_req});
    else n_pass++;
    n = 0;
    do begin step(0, 0, 2'b00, 0, 0); n++; end while (!draw_req && n < 40);
    n_checks++; if (n != 4) $display("FAIL recover_len: got %0d clocks want 4", n); else n_pass++;
    n_checks++;
    if (dut_out !== model_out()) $display("FAIL ack_model: got %h want %h", dut_out, model_out());
    else n_pass++;
  endtask

  task automatic test_aggressive();
    int n;
    step(1, 0, 2'b00, 0, 0);
    step(0, 1, 2'b00, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 2'b00, 1, 0);
    n_checks++;
    if ({health, aggressive} !== {4'd5, 1'b1})
      $display("FAIL aggr_mode: got health %0d aggr %b want 5 1", health, aggressive);
    else n_pass++;
    n = 0;
    while (!telegraph && n < 40) begin step(0, 0, 2'b00, 0, 0); n++; end
    n_checks++; if (n != 3) $display("FAIL aggr_wind_entry: got %0d clocks want 3", n); else n_pass++;
    n = 0;
    while (telegraph && n < 40) begin step(0, 0, 2'b00, 0, 0); n++; end
    n_checks++; if (n != 4) $display("FAIL aggr_wind_len: got %0d clocks want 4", n); else n_pass++;
    n = 0;
    while (!attack_missed && n < 40) begin step(0, 0, 2'b00, 0, 0); n++; end
    n_checks++; if (n != 2) $display("FAIL aggr_missed: got %0d clocks want 2", n); else n_pass++;
  endtask

  task automatic test_stagger();
    int n;
    bit saw_av;
    step(1, 0, 2'b00, 0, 0);
    step(0, 1, 2'b00, 0, 0);
    n = 0;
    while (!telegraph && n < 40) begin step(0, 0, 2'b00, 0, 0); n++; end
    step(0, 0, 2'b00, 1, 0);
    n_checks++;
    if ({telegraph, attack_valid, draw_req, health} !== {3'b001, 4'd9})
      $display("FAIL stagger: got tel/av/draw %b health %0d want 001 9",
               {telegraph, attack_valid, draw_req}, health);
    else n_pass++;
    saw_av = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 2'b00, 0, 0);
      if (attack_valid) saw_av = 1;
    end
    n_checks++; if (saw_av) $display("FAIL stagger_no_attack: got attack_valid 1 want 0"); else n_pass++;
    n_checks++;
    if (dut_out !== model_out()) $display("FAIL stagger_model: got %h want %h", dut_out, model_out());
    else n_pass++;
  endtask

  task automatic test_death();
    int n;
    step(1, 0, 2'b00, 0, 0);
    step(0, 1, 2'b00, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 2'b00, 1, 0);
    n_checks++; if (health !== 4'd1) $display("FAIL death_prep: got health %0d want 1", health); else n_pass++;
    n = 0;
    while (!attack_valid && n < 200) begin step(0, 0, 2'b00, 0, 0); n++; end
    n_checks++; if (!attack_valid) $display("FAIL death_attack: got attack_valid 0 want 1"); else n_pass++;
    step(0, 0, 2'b00, 1, 1);
    n_checks++;
    if ({dead, health, attack_valid, aggressive, attack_missed} !== {1'b1, 4'd0, 3'b000})
      $display("FAIL death_enter: got dead %b health %0d av/aggr/miss %b want 1 0 000",
               dead, health, {attack_valid, aggressive, attack_missed});
    else n_pass++;
    step(0, 0, 2'b00, 1, 0);
    n_checks++;
    if ({dead, health} !== {1'b1, 4'd0}) $display("FAIL dead_hit: got dead %b health %0d want 1 0", dead, health);
    else n_pass++;
    step(0, 1, 2'b00, 0, 0);
    n_checks++;
    if ({dead, health, lane, draw_req, aggressive} !== {1'b0, 4'd10, 2'd1, 1'b1, 1'b0})
      $display("FAIL dead_restart: got dead %b health %0d lane %0d draw %b aggr %b want 0 10 1 1 0",
               dead, health, lane, draw_req, aggressive);
    else n_pass++;
  endtask

  task automatic test_random();
    bit rs, st, h, a;
    logic [1:0] r;
    step(1, 0, 2'b00, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      rs = ($urandom_range(0, 599) == 0);
      st = ($urandom_range(0, 49) == 0);
      r  = 2'($urandom);
      h  = ($urandom_range(0, 11) == 0);
      a  = ($urandom_range(0, 3) == 0);
      step(rs, st, r, h, a);
      n_checks++;
      if (dut_out !== model_out())
        $display("FAIL random_model: cyc %0d got %h want %h", i, dut_out, model_out());
      else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_move_clamp();
    test_wind_timing();
    test_ack();
    test_aggressive();
    test_stagger();
    test_death();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
